// File: rtl/capturador_requisicoes.sv
// capturador_requisicoes: synchronises and debounces two users' switches and buttons, then
// captures one request per button press and holds it until the access-control side
// acknowledges it.
// Build macro TIMEOUT_EN: adds a hold timer that expires an unacknowledged request and
// pulses TIMEOUT; without it PRESENT waits for ACK forever and TIMEOUT is tied low.
module capturador_requisicoes #(
    parameter int unsigned DEB_CYCLES  = 50000,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] SW0,
    input  logic [3:0] SW1,
    input  logic [1:0] BTN0,
    input  logic [1:0] BTN1,
    input  logic       ACK,
    output logic [3:0] HH0,
    output logic [3:0] HH1,
    output logic [1:0] B0,
    output logic [1:0] B1,
    output logic       REQ_VALID,
    output logic       TIMEOUT
);

    localparam int unsigned NumBits = 12;
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
    // Bit layout is {BTN1, BTN0, SW1, SW0}; buttons idle high, switches idle low.
    localparam logic [NumBits-1:0] DebRst = 12'hF00;

    typedef enum logic [1:0] {StIdle, StPresent, StRelease} state_e;

    logic [NumBits-1:0] raw;
    logic [NumBits-1:0] sync1_q;
    logic [NumBits-1:0] sync2_q;
    logic [NumBits-1:0] deb_q;
    logic [NumBits-1:0] deb_d;
    logic [NumBits-1:0] deb_prev_q;
    logic [DebW-1:0]    cnt_q [NumBits];
    logic [DebW-1:0]    cnt_d [NumBits];
    logic [3:0]         arm_q;
    logic               press_evt;
    logic               all_released;
    logic               hold_expired;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] hh0_q;
    logic [3:0] hh1_q;
    logic [1:0] b0_q;
    logic [1:0] b1_q;

    assign raw = {BTN1, BTN0, SW1, SW0};

    // Two-flop synchroniser for every raw input bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a mismatch must persist DEB_CYCLES edges before the output follows.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NumBits; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // Debounce state, previous debounced value for edge detection, and button arming.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q      <= DebRst;
            deb_prev_q <= DebRst;
            arm_q      <= '0;
            for (int i = 0; i < NumBits; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            // A button only counts once it has been seen released, so one held through
            // reset cannot fake a press when its debounced value settles low.
            arm_q      <= arm_q | (sync2_q[11:8] & deb_q[11:8]);
            for (int i = 0; i < NumBits; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press_evt    = |(deb_prev_q[11:8] & ~deb_q[11:8] & arm_q);
    assign all_released = &deb_q[11:8];

`ifdef TIMEOUT_EN
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    logic [HoldW-1:0] hold_q;
    logic             timeout_q;

    // Hold timer runs only while presenting, so it starts from zero on every entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
        end else if (state_q != StPresent) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + HoldW'(1);
        end
    end

    assign hold_expired = (state_q == StPresent) && (hold_q == HoldLast);

    // TIMEOUT pulses with the move to RELEASE; a coincident ACK suppresses it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= hold_expired & ~ACK;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    logic unused_hold_cfg;

    assign unused_hold_cfg = ^HOLD_CYCLES;
    assign hold_expired    = 1'b0;
    assign TIMEOUT         = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: presses outside IDLE and ACK outside PRESENT are simply not looked at.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (press_evt) state_d = StPresent;
            StPresent: if (ACK || hold_expired) state_d = StRelease;
            StRelease: if (all_released) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Capture every debounced switch and button when a request is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hh0_q <= 4'b0000;
            hh1_q <= 4'b0000;
            b0_q  <= 2'b11;
            b1_q  <= 2'b11;
        end else if (state_q == StIdle && press_evt) begin
            hh0_q <= deb_q[3:0];
            hh1_q <= deb_q[7:4];
            b0_q  <= deb_q[9:8];
            b1_q  <= deb_q[11:10];
        end
    end

    // FSM outputs: button codes and valid are shown only while presenting.
    always_comb begin
        HH0       = hh0_q;
        HH1       = hh1_q;
        B0        = 2'b11;
        B1        = 2'b11;
        REQ_VALID = 1'b0;
        if (state_q == StPresent) begin
            B0        = b0_q;
            B1        = b1_q;
            REQ_VALID = 1'b1;
        end
    end

endmodule

// File: tb/tb_capturador_requisicoes.sv
// Self-checking bench for capturador_requisicoes (DEB_CYCLES=4, HOLD_CYCLES=10).
module tb_capturador_requisicoes;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Hold = 10;
`ifdef TIMEOUT_EN
    localparam bit TimeoutBuild = 1'b1;
`else
    localparam bit TimeoutBuild = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw0 = 4'h0;
    logic [3:0] sw1 = 4'h0;
    logic [1:0] btn0 = 2'b11;
    logic [1:0] btn1 = 2'b11;
    logic       ack = 1'b0;
    logic [3:0] hh0;
    logic [3:0] hh1;
    logic [1:0] b0;
    logic [1:0] b1;
    logic       req_valid;
    logic       timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    capturador_requisicoes #(
        .DEB_CYCLES (Deb),
        .HOLD_CYCLES(Hold)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .SW0      (sw0),
        .SW1      (sw1),
        .BTN0     (btn0),
        .BTN1     (btn1),
        .ACK      (ack),
        .HH0      (hh0),
        .HH1      (hh1),
        .B0       (b0),
        .B1       (b1),
        .REQ_VALID(req_valid),
        .TIMEOUT  (timeout)
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [3:0] eh0,
                              input logic [3:0] eh1, input logic [1:0] eb0,
                              input logic [1:0] eb1, input logic eto);
        cmp({tag, ".valid"}, 16'(req_valid), 16'(ev));
        cmp({tag, ".hh0"}, 16'(hh0), 16'(eh0));
        cmp({tag, ".hh1"}, 16'(hh1), 16'(eh1));
        cmp({tag, ".b0"}, 16'(b0), 16'(eb0));
        cmp({tag, ".b1"}, 16'(b1), 16'(eb1));
        cmp({tag, ".timeout"}, 16'(timeout), 16'(eto));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    bit          model_on = 1'b0;
    logic [11:0] m_raw1;
    logic [11:0] m_raw2;
    logic [11:0] m_deb;
    logic [11:0] m_prev;
    logic [3:0]  m_arm;
    logic [11:0] m_win[$];
    int          m_mode;  // 0 idle, 1 presenting, 2 waiting for all buttons released
    int          m_pc;    // cycles spent presenting so far
    logic [3:0]  m_chh0;
    logic [3:0]  m_chh1;
    logic [1:0]  m_cb0;
    logic [1:0]  m_cb1;
    logic        m_to;

    always @(posedge clk) begin : model
        logic [11:0] syn;
        logic [11:0] flip;
        logic [3:0]  fell;
        if (!model_on) begin
            m_raw1 = '0;
            m_raw2 = '0;
            m_deb  = 12'hF00;
            m_prev = 12'hF00;
            m_arm  = '0;
            m_win.delete();
            for (int k = 0; k < Deb; k++) m_win.push_back(12'hF00);
            m_mode = 0;
            m_pc   = 0;
            m_chh0 = '0;
            m_chh1 = '0;
            m_cb0  = 2'b11;
            m_cb1  = 2'b11;
            m_to   = 1'b0;
        end else begin
            syn = m_raw2;
            m_win.push_back(syn);
            void'(m_win.pop_front());
            // A bit follows only when every one of the last Deb synced samples disagreed.
            flip = '1;
            foreach (m_win[k]) flip &= m_win[k] ^ m_deb;
            fell = m_prev[11:8] & ~m_deb[11:8] & m_arm;
            m_to = 1'b0;
            case (m_mode)
                0: if (fell != 0) begin
                    m_chh0 = m_deb[3:0];
                    m_chh1 = m_deb[7:4];
                    m_cb0  = m_deb[9:8];
                    m_cb1  = m_deb[11:10];
                    m_mode = 1;
                    m_pc   = 1;
                end
                1: if (ack) begin
                    m_mode = 2;
                end else if (TimeoutBuild && m_pc == Hold) begin
                    m_mode = 2;
                    m_to   = 1'b1;
                end else begin
                    m_pc++;
                end
                default: if (m_deb[11:8] == 4'hF) m_mode = 0;
            endcase
            m_arm  = m_arm | (syn[11:8] & m_deb[11:8]);
            m_prev = m_deb;
            m_deb  = m_deb ^ flip;
            m_raw2 = m_raw1;
            m_raw1 = {btn1, btn0, sw1, sw0};
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] sw0;
        logic [3:0] sw1;
        logic [1:0] btn0;
        logic [1:0] btn1;
        logic       ack;
        int         n;
        logic       valid;
        logic [3:0] hh0;
        logic [3:0] hh1;
        logic [1:0] b0;
        logic [1:0] b1;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int hold_left;
        int drops;

        vecs[0]  = '{4'h0, 4'h0, 2'b11, 2'b11, 1'b0, 10, 1'b0, 4'h0, 4'h0, 2'b11, 2'b11};
        vecs[1]  = '{4'hB, 4'h0, 2'b10, 2'b11, 1'b0, 6,  1'b0, 4'h0, 4'h0, 2'b11, 2'b11};
        vecs[2]  = '{4'hB, 4'h0, 2'b10, 2'b11, 1'b0, 1,  1'b1, 4'hB, 4'h0, 2'b10, 2'b11};
        vecs[3]  = '{4'h0, 4'h0, 2'b10, 2'b11, 1'b0, 5,  1'b1, 4'hB, 4'h0, 2'b10, 2'b11};
        vecs[4]  = '{4'h0, 4'h0, 2'b10, 2'b11, 1'b1, 1,  1'b0, 4'hB, 4'h0, 2'b11, 2'b11};
        vecs[5]  = '{4'h0, 4'h0, 2'b10, 2'b11, 1'b0, 10, 1'b0, 4'hB, 4'h0, 2'b11, 2'b11};
        vecs[6]  = '{4'h0, 4'h0, 2'b11, 2'b11, 1'b0, 8,  1'b0, 4'hB, 4'h0, 2'b11, 2'b11};
        vecs[7]  = '{4'h0, 4'h6, 2'b01, 2'b10, 1'b0, 6,  1'b0, 4'hB, 4'h0, 2'b11, 2'b11};
        vecs[8]  = '{4'h0, 4'h6, 2'b01, 2'b10, 1'b0, 1,  1'b1, 4'h0, 4'h6, 2'b01, 2'b10};
        vecs[9]  = '{4'h0, 4'h6, 2'b01, 2'b10, 1'b1, 1,  1'b0, 4'h0, 4'h6, 2'b11, 2'b11};
        vecs[10] = '{4'h0, 4'h0, 2'b11, 2'b11, 1'b0, 10, 1'b0, 4'h0, 4'h6, 2'b11, 2'b11};

        repeat (3) @(negedge clk);
        check_outs("in_reset", 1'b0, 4'h0, 4'h0, 2'b11, 2'b11, 1'b0);
        rst_n = 1'b1;
        cycles(10);

        for (int i = 0; i < 11; i++) begin
            sw0  = vecs[i].sw0;
            sw1  = vecs[i].sw1;
            btn0 = vecs[i].btn0;
            btn1 = vecs[i].btn1;
            ack  = vecs[i].ack;
            cycles(vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].hh0, vecs[i].hh1,
                       vecs[i].b0, vecs[i].b1, 1'b0);
        end

        // Bouncing button never settles long enough to count as a press.
        for (int i = 0; i < 10; i++) begin
            btn0 = (i % 2 == 0) ? 2'b10 : 2'b11;
            cycles(2);
            cmp($sformatf("bounce%0d.valid", i), 16'(req_valid), 16'h0);
        end
        cycles(10);
        cmp("bounce_end.valid", 16'(req_valid), 16'h0);

        // Unacknowledged request: expires only in the timer build.
        sw1  = 4'h3;
        btn1 = 2'b01;
        cycles(7);
        check_outs("hold_start", 1'b1, 4'h0, 4'h3, 2'b11, 2'b01, 1'b0);
        if (TimeoutBuild) begin
            for (int k = 1; k < 10; k++) begin
                cycles(1);
                cmp($sformatf("hold%0d.valid", k), 16'(req_valid), 16'h1);
                cmp($sformatf("hold%0d.timeout", k), 16'(timeout), 16'h0);
            end
            cycles(1);
            cmp("expire.valid", 16'(req_valid), 16'h0);
            cmp("expire.timeout", 16'(timeout), 16'h1);
            cycles(1);
            cmp("after_expire.timeout", 16'(timeout), 16'h0);
        end else begin
            drops = 0;
            for (int k = 0; k < 1000; k++) begin
                cycles(1);
                if (req_valid !== 1'b1 || timeout !== 1'b0) drops++;
            end
            cmp("hold_1000.drops", 16'(drops), 16'h0);
            ack = 1'b1;
            cycles(1);
            ack = 1'b0;
            cmp("hold_ack.valid", 16'(req_valid), 16'h0);
        end
        btn1 = 2'b11;
        cycles(10);

        // Held button after ACK; other user's press during RELEASE is dropped.
        btn0 = 2'b10;
        cycles(7);
        cmp("rel_req.valid", 16'(req_valid), 16'h1);
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        cmp("rel_ack.valid", 16'(req_valid), 16'h0);
        cmp("rel_ack.b0", 16'(b0), 16'h3);
        btn1 = 2'b10;
        cycles(10);
        cmp("rel_other.valid", 16'(req_valid), 16'h0);
        btn0 = 2'b11;
        cycles(10);
        cmp("rel_one_up.valid", 16'(req_valid), 16'h0);
        btn1 = 2'b11;
        cycles(10);
        cmp("rel_all_up.valid", 16'(req_valid), 16'h0);
        btn1 = 2'b01;
        cycles(7);
        cmp("rel_new.valid", 16'(req_valid), 16'h1);
        cmp("rel_new.b1", 16'(b1), 16'h1);
        cmp("rel_new.b0", 16'(b0), 16'h3);
        ack = 1'b1;
        cycles(1);
        ack  = 1'b0;
        btn1 = 2'b11;
        cycles(10);

        // Reset in the middle of PRESENT clears outputs without waiting for a clock.
        sw0  = 4'h5;
        btn0 = 2'b10;
        cycles(7);
        cmp("pre_rst.valid", 16'(req_valid), 16'h1);
        #2 rst_n = 1'b0;
        #1 check_outs("rst_async", 1'b0, 4'h0, 4'h0, 2'b11, 2'b11, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(30);
        cmp("held_thru_rst.valid", 16'(req_valid), 16'h0);
        btn0 = 2'b11;
        cycles(10);
        btn0 = 2'b10;
        cycles(7);
        cmp("repress.valid", 16'(req_valid), 16'h1);
        cmp("repress.hh0", 16'(hh0), 16'h5);
        ack = 1'b1;
        cycles(1);
        ack  = 1'b0;
        btn0 = 2'b11;
        cycles(10);

        // Randomised run against the reference model, from a fresh reset.
        rst_n = 1'b0;
        sw0   = 4'h0;
        sw1   = 4'h0;
        btn0  = 2'b11;
        btn1  = 2'b11;
        ack   = 1'b0;
        cycles(2);
        rst_n    = 1'b1;
        model_on = 1'b1;
        hold_left = 10;
        for (int i = 0; i < 3000; i++) begin
            check_outs($sformatf("rand%0d", i), (m_mode == 1), m_chh0, m_chh1,
                       (m_mode == 1) ? m_cb0 : 2'b11, (m_mode == 1) ? m_cb1 : 2'b11, m_to);
            if (hold_left == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    btn0 = 2'b11;
                    btn1 = 2'b11;
                end else begin
                    btn0 = 2'($urandom_range(0, 3));
                    btn1 = 2'($urandom_range(0, 3));
                end
                sw0       = 4'($urandom_range(0, 15));
                sw1       = 4'($urandom_range(0, 15));
                hold_left = int'($urandom_range(1, 14));
            end else begin
                hold_left--;
            end
            ack = ($urandom_range(0, 15) == 0);
            cycles(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capturador_requisicoes.md
CAPTURADOR_REQUISICOES -- requirements
Module: capturador_requisicoes

Interface
REQ-001 Parameter DEB_CYCLES, default 50000, SHALL set consecutive stable cycles required before a debounced input changes (1 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000, SHALL set the cycles PRESENT waits for ACK before timing out (TIMEOUT_EN builds only).
REQ-003 CLK  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 SW0, SW1  input  4 each  SHALL be raw user switches (bits 3:1 user code, bit 0 function bit), asynchronous to CLK.
REQ-006 BTN0, BTN1  input  2 each  SHALL be raw user buttons, active-low (0 = pressed), asynchronous to CLK.
REQ-007 ACK  input  1  SHALL be the access-control side's acknowledge of the presented request.
REQ-008 HH0, HH1  output  4 each  SHALL be the registered switch codes presented to the access-control block.
REQ-009 B0, B1  output  2 each  SHALL be the registered active-low button codes presented to the access-control block.
REQ-010 REQ_VALID  output  1  SHALL be high while HH0/HH1/B0/B1 hold a captured request.
REQ-011 TIMEOUT  output  1  SHALL be a one-cycle pulse when a request expires without ACK.

Function
REQ-012 Each of the 12 raw bits SHALL pass through a 2-flop synchronizer, then a per-bit debouncer.
REQ-013 Debouncer: counter clears whenever synced value equals debounced value; debounced value SHALL take synced value when counter reaches DEB_CYCLES-1 with a mismatch held every cycle.
REQ-014 A press event SHALL be any debounced button bit transitioning 1->0, either user.
REQ-015 FSM states SHALL be IDLE, PRESENT, RELEASE; encoding free.
REQ-016 IDLE: outputs B0=B1=2'b11, REQ_VALID=0; on press event SHALL latch all debounced SW0/SW1/BTN0/BTN1 into HH0/HH1/B0/B1 and enter PRESENT; REQ_VALID high the cycle after the event.
REQ-017 Presses from both users in the same cycle SHALL be captured together in one request.
REQ-018 PRESENT: outputs SHALL hold constant regardless of switch/button changes; ACK high SHALL move to RELEASE next cycle.
REQ-019 RELEASE: REQ_VALID=0, B0=B1=2'b11, HH0/HH1 retain last value; SHALL return to IDLE only when all four debounced button bits are 1.
REQ-020 Press events occurring outside IDLE SHALL be discarded, not queued.
REQ-021 ACK while in IDLE or RELEASE SHALL be ignored.
REQ-022 Raw-to-REQ_VALID latency SHALL be 2 + DEB_CYCLES + 1 cycles for a clean press.

Reset
REQ-023 RST_N low SHALL immediately force: state IDLE, HH0=HH1=4'b0000, B0=B1=2'b11, REQ_VALID=0, TIMEOUT=0, synchronizers and debounced switches 0, debounced buttons 1, all counters 0.
REQ-024 Reset asserted mid-PRESENT SHALL drop the request with no TIMEOUT pulse; after release, a still-held button SHALL not produce a press event until released and pressed again.

Configuration
REQ-025 Macro TIMEOUT_EN defined: a hold counter SHALL clear on PRESENT entry; on reaching HOLD_CYCLES-1 without ACK, FSM enters RELEASE and TIMEOUT pulses one cycle; ACK on that same cycle wins, no TIMEOUT.
REQ-026 Macro TIMEOUT_EN undefined: PRESENT SHALL wait for ACK indefinitely; TIMEOUT tied 0; no hold counter synthesized.

Verification (DEB_CYCLES=4, HOLD_CYCLES=10)
REQ-027 Reset, no stimulus -> HH0=HH1=0000, B0=B1=11, REQ_VALID=0, TIMEOUT=0 indefinitely.
REQ-028 SW0=1011, BTN0 10 held steady -> REQ_VALID=1 at cycle 7 after change, HH0=1011, B0=10, B1=11; ACK pulse -> REQ_VALID=0 next cycle, B0=11.
REQ-029 BTN0 bouncing 0/1 every 2 cycles for 20 cycles then stable 1 -> no press event, REQ_VALID stays 0.
REQ-030 BTN0=01 and BTN1=10 same cycle, SW1=0110 -> single request, B0=01, B1=10, HH1=0110.
REQ-031 TIMEOUT_EN build, press, no ACK -> TIMEOUT high exactly one cycle after 10 PRESENT cycles, REQ_VALID=0; non-TIMEOUT_EN build -> REQ_VALID stays 1 for 1000 cycles.
REQ-032 Held button after ACK, second user presses during RELEASE -> no new request until all buttons released; RST_N pulse during PRESENT -> outputs return to reset values asynchronously.
